hazard_forward_unit: RTL and testbench

- Consumes the 6-bit register IDs produced by the ID-stage read/write register decoder.
- ID space: 0–31 are GPRs; 33 is HI/LO; 0 means "none".
- Tracks in-flight destination IDs through the EX, MEM and WB stages.
- Drives the operand forwarding selects and the load-use stall for the 5-stage MIPS pipeline.

---
 rtl/hazard_forward_unit_if.sv | 26 ++
 rtl/hazard_forward_unit.sv | 104 ++++++++++
 tb/tb_hazard_forward_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// ID-stage to hazard/forwarding unit bus: decoded register IDs in,
// forwarding selects, load-use stall and EX destination out.
interface hazard_forward_unit_if #(
    parameter int REG_W = 6
);
    logic             id_valid;
    logic [REG_W-1:0] id_rreg1;
    logic [REG_W-1:0] id_rreg2;
    logic [REG_W-1:0] id_wreg;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [REG_W-1:0] ex_wreg;

    modport master (
        output id_valid, id_rreg1, id_rreg2, id_wreg, id_is_load, flush,
        input  stall, fwd_sel1, fwd_sel2, ex_wreg
    );

    modport slave (
        input  id_valid, id_rreg1, id_rreg2, id_wreg, id_is_load, flush,
        output stall, fwd_sel1, fwd_sel2, ex_wreg
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage MIPS pipeline.
// Tracks destination register IDs in EX/MEM/WB and produces forward
// selects (0 regfile, 1 EX, 2 MEM, 3 WB) plus the load-use stall.
// FWD_EN=0 turns every RAW hazard against EX/MEM/WB into a stall.
// Optional: define HAZARD_STALL_CNT_EN to add the 32-bit stall_cnt output.
module hazard_forward_unit #(
    parameter int REG_W  = 6,
    parameter bit FWD_EN = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_forward_unit_if.slave bus
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    // Only EX needs is_load: the load-use check never looks past EX.
    logic             ex_valid;
    logic [REG_W-1:0] ex_wreg_q;
    logic             ex_load;
    logic             mem_valid;
    logic [REG_W-1:0] mem_wreg;
    logic             wb_valid;
    logic [REG_W-1:0] wb_wreg;

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic stall_int;

    function automatic logic [1:0] pick(input logic ex_m, input logic mem_m,
                                        input logic wb_m);
        if (ex_m)       return 2'd1;
        else if (mem_m) return 2'd2;
        else if (wb_m)  return 2'd3;
        else            return 2'd0;
    endfunction

    // Per-slot match against both read IDs; ID 0 never matches.
    always_comb begin
        ex_m1  = ex_valid  && (ex_wreg_q == bus.id_rreg1) && (bus.id_rreg1 != '0);
        ex_m2  = ex_valid  && (ex_wreg_q == bus.id_rreg2) && (bus.id_rreg2 != '0);
        mem_m1 = mem_valid && (mem_wreg  == bus.id_rreg1) && (bus.id_rreg1 != '0);
        mem_m2 = mem_valid && (mem_wreg  == bus.id_rreg2) && (bus.id_rreg2 != '0);
        wb_m1  = wb_valid  && (wb_wreg   == bus.id_rreg1) && (bus.id_rreg1 != '0);
        wb_m2  = wb_valid  && (wb_wreg   == bus.id_rreg2) && (bus.id_rreg2 != '0);
    end

    // Stall decision and forward selects, youngest producer wins.
    always_comb begin
        stall_int    = 1'b0;
        bus.fwd_sel1 = 2'd0;
        bus.fwd_sel2 = 2'd0;
        if (FWD_EN) begin
            stall_int = bus.id_valid && !bus.flush && ex_valid && ex_load &&
                        (ex_m1 || ex_m2);
            if (bus.id_valid) begin
                bus.fwd_sel1 = pick(ex_m1, mem_m1, wb_m1);
                bus.fwd_sel2 = pick(ex_m2, mem_m2, wb_m2);
            end
        end else begin
            stall_int = bus.id_valid && !bus.flush &&
                        (ex_m1 || ex_m2 || mem_m1 || mem_m2 || wb_m1 || wb_m2);
        end
        bus.stall   = stall_int;
        bus.ex_wreg = ex_wreg_q;
    end

    // Advance the stage slots; EX takes a bubble on stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_wreg_q <= '0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_wreg  <= '0;
            wb_valid  <= 1'b0;
            wb_wreg   <= '0;
        end else begin
            wb_valid  <= mem_valid;
            wb_wreg   <= mem_wreg;
            mem_valid <= ex_valid;
            mem_wreg  <= ex_wreg_q;
            if (stall_int || bus.flush) begin
                ex_valid  <= 1'b0;
                ex_wreg_q <= '0;
                ex_load   <= 1'b0;
            end else begin
                ex_valid  <= bus.id_valid && (bus.id_wreg != '0);
                ex_wreg_q <= bus.id_wreg;
                ex_load   <= bus.id_is_load;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Count stalled cycles; flush cycles never stall so are never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         stall_cnt <= '0;
        else if (stall_int) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a FWD_EN=1 and a FWD_EN=0
// instance, directed vectors with hand-computed expectations.
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_W(6)) ifa ();
    hazard_forward_unit_if #(.REG_W(6)) ifb ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    hazard_forward_unit #(.REG_W(6), .FWD_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(cnt_a)
`endif
    );

    hazard_forward_unit #(.REG_W(6), .FWD_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(cnt_b)
`endif
    );

    typedef struct {
        string       name;
        bit          dut;
        logic        stall;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [5:0]  exw;
        bit          chk_fwd;
        bit          chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic step(input string name, input bit dut, input bit rst,
                        input bit v, input logic [5:0] r1, input logic [5:0] r2,
                        input logic [5:0] w, input bit ld, input bit fl,
                        input logic es, input logic [1:0] e1, input logic [1:0] e2,
                        input logic [5:0] ex, input bit cf, input bit cc,
                        input logic [31:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        if (dut == 1'b0) begin
            ifa.id_valid = v; ifa.id_rreg1 = r1; ifa.id_rreg2 = r2;
            ifa.id_wreg = w; ifa.id_is_load = ld; ifa.flush = fl;
        end else begin
            ifb.id_valid = v; ifb.id_rreg1 = r1; ifb.id_rreg2 = r2;
            ifb.id_wreg = w; ifb.id_is_load = ld; ifb.flush = fl;
        end
        e.name = name; e.dut = dut; e.stall = es; e.f1 = e1; e.f2 = e2;
        e.exw = ex; e.chk_fwd = cf; e.chk_cnt = cc; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs settle after the drive at posedge+1; sample on negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic gs;
            logic [1:0] g1, g2;
            logic [5:0] gx;
            logic [31:0] gc;
            bit ok;
            e = exp_q.pop_front();
            if (e.dut == 1'b0) begin
                gs = ifa.stall; g1 = ifa.fwd_sel1; g2 = ifa.fwd_sel2; gx = ifa.ex_wreg;
            end else begin
                gs = ifb.stall; g1 = ifb.fwd_sel1; g2 = ifb.fwd_sel2; gx = ifb.ex_wreg;
            end
            gc = 32'd0;
`ifdef HAZARD_STALL_CNT_EN
            gc = (e.dut == 1'b0) ? cnt_a : cnt_b;
`endif
            ok = (gs === e.stall) && (gx === e.exw) &&
                 (!e.chk_fwd || ((g1 === e.f1) && (g2 === e.f2)));
`ifdef HAZARD_STALL_CNT_EN
            if (e.chk_cnt) ok = ok && (gc === e.cnt);
`endif
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got stall=%0b f1=%0d f2=%0d ex_wreg=%0d cnt=%0d, expected stall=%0b f1=%0d f2=%0d ex_wreg=%0d cnt=%0d",
                         e.name, gs, g1, g2, gx, gc, e.stall, e.f1, e.f2, e.exw, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.id_valid = 0; ifa.id_rreg1 = 0; ifa.id_rreg2 = 0; ifa.id_wreg = 0;
        ifa.id_is_load = 0; ifa.flush = 0;
        ifb.id_valid = 0; ifb.id_rreg1 = 0; ifb.id_rreg2 = 0; ifb.id_wreg = 0;
        ifb.id_is_load = 0; ifb.flush = 0;

        //    name          dut rst v  r1  r2  w  ld fl  st f1 f2 exw cf cc cnt
        step("reset",        0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 1, 1, 0);
        // ALU producer of 8, then readers at distance 1..4
        step("alu_add8",     0, 1, 1,  1,  2,  8, 0, 0,  0, 0, 0,  0, 1, 1, 0);
        step("fwd_ex",       0, 1, 1,  8,  0,  0, 0, 0,  0, 1, 0,  8, 1, 0, 0);
        step("fwd_mem",      0, 1, 1,  3,  8,  0, 0, 0,  0, 0, 2,  0, 1, 0, 0);
        step("fwd_wb",       0, 1, 1,  8,  0,  0, 0, 0,  0, 3, 0,  0, 1, 0, 0);
        step("fwd_gone",     0, 1, 1,  8,  8,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        // Load-use on operand 2
        step("lw9",          0, 1, 1,  1,  0,  9, 1, 0,  0, 0, 0,  0, 1, 0, 0);
        step("lu_stall",     0, 1, 1,  0,  9, 12, 0, 0,  1, 0, 0,  9, 0, 1, 0);
        step("lu_after",     0, 1, 1,  0,  9, 12, 0, 0,  0, 0, 2,  0, 1, 1, 1);
        step("lu_next",      0, 1, 1,  0,  0,  0, 0, 0,  0, 0, 0, 12, 1, 0, 0);
        // Priority: EX and MEM both write 5
        step("prio_w5a",     0, 1, 1,  0,  0,  5, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        step("prio_w5b",     0, 1, 1,  0,  0,  5, 0, 0,  0, 0, 0,  5, 1, 0, 0);
        step("prio_rd5",     0, 1, 1,  5,  5,  0, 0, 0,  0, 1, 1,  5, 1, 0, 0);
        step("invalid_id",   0, 1, 0,  5,  5,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        // Zero register and HI/LO
        step("w_zero",       0, 1, 1,  0,  0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        step("rd_zero_w33",  0, 1, 1,  0,  0, 33, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        step("mflo_33",      0, 1, 1, 33,  0,  0, 0, 0,  0, 1, 0, 33, 1, 0, 0);
        // Flush overrides load-use stall
        step("lw20",         0, 1, 1,  0,  0, 20, 1, 0,  0, 0, 0,  0, 1, 0, 0);
        step("flush_lu",     0, 1, 1, 20,  0, 21, 0, 1,  0, 1, 0, 20, 1, 0, 0);
        step("post_flush",   0, 1, 1, 20,  0,  0, 0, 0,  0, 2, 0,  0, 1, 1, 1);

        // FWD_EN=0 instance: full RAW stall through EX/MEM/WB
        step("nf_w7",        1, 1, 1,  0,  0,  7, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        step("nf_stall_ex",  1, 1, 1,  7,  0,  0, 0, 0,  1, 0, 0,  7, 1, 0, 0);
        step("nf_stall_mem", 1, 1, 1,  7,  0,  0, 0, 0,  1, 0, 0,  0, 1, 0, 0);
        step("nf_stall_wb",  1, 1, 1,  7,  0,  0, 0, 0,  1, 0, 0,  0, 1, 0, 0);
        step("nf_release",   1, 1, 1,  7,  0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        // Reset asserted mid-stall
        step("nf_w7b",       1, 1, 1,  0,  0,  7, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        step("nf_stall2",    1, 1, 1,  0,  7,  0, 0, 0,  1, 0, 0,  7, 1, 0, 0);
        step("nf_rst_mid",   1, 0, 1,  0,  7,  0, 0, 0,  0, 0, 0,  0, 1, 1, 0);
        step("nf_post_rst",  1, 1, 1,  0,  7,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
